// File: rtl/sdram_line_port.sv
// Cache-line sequencer for the Gowin SDRAM_Controller_HS_Top: turns line read/write
// requests into ACTIVE + READ/WRITE (auto-precharge) bursts and interleaves auto-refresh.
module sdram_line_port #(
    parameter int unsigned LineWordsBitWidth     = 3,
    parameter int unsigned ActivateWaitCycles    = 2,
    parameter int unsigned ReadDataLatency       = 6,
    parameter int unsigned RecoveryCycles        = 4,
    parameter int unsigned RefreshIntervalCycles = 300,
    parameter int unsigned RefreshWaitCycles     = 8
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      req_valid,
    input  logic                                      req_write,
    input  logic [20:0]                               req_address,
    input  logic [32*(1<<LineWordsBitWidth)-1:0]      wr_line,
    output logic [32*(1<<LineWordsBitWidth)-1:0]      rd_line,
    output logic                                      rd_valid,
    output logic                                      busy,
    output logic                                      I_sdrc_cmd_en,
    output logic [2:0]                                I_sdrc_cmd,
    output logic                                      I_sdrc_precharge_ctrl,
    output logic                                      I_sdram_power_down,
    output logic                                      I_sdram_selfrefresh,
    output logic [20:0]                               I_sdrc_addr,
    output logic [3:0]                                I_sdrc_dqm,
    output logic [31:0]                               I_sdrc_data,
    output logic [7:0]                                I_sdrc_data_len,
    input  logic [31:0]                               O_sdrc_data,
    input  logic                                      O_sdrc_init_done,
    input  logic                                      O_sdrc_cmd_ack
);
    localparam int unsigned LineWords = 1 << LineWordsBitWidth;
    localparam int unsigned LineBits  = 32 * LineWords;
    localparam logic [2:0] CMD_ACTIVE  = 3'b011;
    localparam logic [2:0] CMD_READ    = 3'b101;
    localparam logic [2:0] CMD_WRITE   = 3'b100;
    localparam logic [2:0] CMD_REFRESH = 3'b001;
    localparam logic [2:0] CMD_NOP     = 3'b111;
    localparam logic [20:0] LineMask   = ~21'(LineWords - 1);
    localparam logic [LineWordsBitWidth-1:0] LastWord = LineWordsBitWidth'(LineWords - 1);

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_ACT_ACK, S_ACT_WAIT, S_WR_DATA,
        S_RD_WAIT, S_RD_DATA, S_RECOVER, S_REF_ACK, S_REF_WAIT
    } state_t;

    state_t                         state_q, state_d;
    logic [15:0]                    cnt_q, cnt_d;
    logic [LineWordsBitWidth-1:0]   widx_q, widx_d, widx_nx;
    logic                           cmd_en_d;
    logic [2:0]                     cmd_d;
    logic [20:0]                    addr_d;
    logic [31:0]                    data_d;
    logic                           accept, ref_issue;
    logic                           rd_last_d, rd_last_q;
    logic                           req_write_q;
    logic [20:0]                    addr_q;
    logic [LineBits-1:0]            wr_buf_q, rd_buf_q;
    logic [15:0]                    ref_cnt_q;
    logic                           refresh_pending_q;

    assign widx_nx = widx_q + LineWordsBitWidth'(1);

    assign busy                  = (state_q != S_IDLE) || refresh_pending_q;
    assign I_sdrc_precharge_ctrl = 1'b1;
    assign I_sdram_power_down    = 1'b0;
    assign I_sdram_selfrefresh   = 1'b0;
    assign I_sdrc_dqm            = '0;
    assign I_sdrc_data_len       = 8'(LineWords - 1);

    // Command outputs are registered: next-cycle values are decided here.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        widx_d    = widx_q;
        cmd_en_d  = 1'b0;
        cmd_d     = CMD_NOP;
        addr_d    = I_sdrc_addr;
        data_d    = '0;
        accept    = 1'b0;
        ref_issue = 1'b0;
        rd_last_d = 1'b0;
        case (state_q)
            S_INIT: begin
                if (O_sdrc_init_done) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (refresh_pending_q) begin
                    ref_issue = 1'b1;
                    cmd_en_d  = 1'b1;
                    cmd_d     = CMD_REFRESH;
                    state_d   = S_REF_ACK;
                end else if (req_valid) begin
                    accept   = 1'b1;
                    cmd_en_d = 1'b1;
                    cmd_d    = CMD_ACTIVE;
                    addr_d   = {req_address[20:8], 8'h00};
                    state_d  = S_ACT_ACK;
                end
            end
            S_ACT_ACK: begin
                if (O_sdrc_cmd_ack) begin
                    state_d = S_ACT_WAIT;
                    cnt_d   = 16'(ActivateWaitCycles - 1);
                end
            end
            S_ACT_WAIT: begin
                if (cnt_q == '0) begin
                    cmd_en_d = 1'b1;
                    addr_d   = addr_q;
                    widx_d   = '0;
                    if (req_write_q) begin
                        cmd_d   = CMD_WRITE;
                        data_d  = wr_buf_q[31:0];
                        state_d = S_WR_DATA;
                    end else begin
                        cmd_d   = CMD_READ;
                        cnt_d   = 16'(ReadDataLatency - 1);
                        state_d = S_RD_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_WR_DATA: begin
                if (widx_q == LastWord) begin
                    state_d = S_RECOVER;
                    cnt_d   = 16'(RecoveryCycles - 1);
                end else begin
                    widx_d = widx_nx;
                    data_d = wr_buf_q[{widx_nx, 5'd0} +: 32];
                end
            end
            S_RD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RD_DATA;
                    widx_d  = '0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_RD_DATA: begin
                if (widx_q == LastWord) begin
                    rd_last_d = 1'b1;
                    state_d   = S_RECOVER;
                    cnt_d     = 16'(RecoveryCycles - 1);
                end else begin
                    widx_d = widx_nx;
                end
            end
            S_RECOVER: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else cnt_d = cnt_q - 16'd1;
            end
            S_REF_ACK: begin
                if (O_sdrc_cmd_ack) begin
                    state_d = S_REF_WAIT;
                    cnt_d   = 16'(RefreshWaitCycles - 1);
                end
            end
            S_REF_WAIT: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else cnt_d = cnt_q - 16'd1;
            end
            default: state_d = S_INIT;
        endcase
        // Losing init_done overrides everything, including a command about to issue.
        if (!O_sdrc_init_done) begin
            state_d   = S_INIT;
            cmd_en_d  = 1'b0;
            cmd_d     = CMD_NOP;
            data_d    = '0;
            accept    = 1'b0;
            ref_issue = 1'b0;
            rd_last_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_INIT;
            cnt_q         <= '0;
            widx_q        <= '0;
            I_sdrc_cmd_en <= 1'b0;
            I_sdrc_cmd    <= CMD_NOP;
            I_sdrc_addr   <= '0;
            I_sdrc_data   <= '0;
            req_write_q   <= 1'b0;
            addr_q        <= '0;
            wr_buf_q      <= '0;
            rd_buf_q      <= '0;
            rd_last_q     <= 1'b0;
            rd_valid      <= 1'b0;
            rd_line       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            widx_q        <= widx_d;
            I_sdrc_cmd_en <= cmd_en_d;
            I_sdrc_cmd    <= cmd_d;
            I_sdrc_addr   <= addr_d;
            I_sdrc_data   <= data_d;
            if (accept) begin
                req_write_q <= req_write;
                addr_q      <= req_address & LineMask;
                wr_buf_q    <= wr_line;
            end
            if (state_q == S_RD_DATA) rd_buf_q[{widx_q, 5'd0} +: 32] <= O_sdrc_data;
            // rd_line only changes once a whole line is in, so it stays stable between reads.
            rd_last_q <= rd_last_d;
            rd_valid  <= rd_last_q;
            if (rd_last_q) rd_line <= rd_buf_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_q         <= 16'(RefreshIntervalCycles - 1);
            refresh_pending_q <= 1'b0;
        end else begin
            if (ref_cnt_q == '0) ref_cnt_q <= 16'(RefreshIntervalCycles - 1);
            else ref_cnt_q <= ref_cnt_q - 16'd1;
            if (ref_cnt_q == '0) refresh_pending_q <= 1'b1;
            else if (ref_issue) refresh_pending_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdram_line_port.sv
// Bench for sdram_line_port: SDRAM controller model with command/word/line scoreboards.
`timescale 1ns/1ps
module tb_sdram_line_port;
    localparam int ACT_WAIT = 2;
    localparam int RD_LAT   = 6;
    localparam int REC      = 4;
    localparam int REF_INT  = 300;
    localparam int REF_WAIT = 8;
    localparam int ACK_DLY  = 2;
    localparam logic [2:0] C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100, C_REF = 3'b001, C_NOP = 3'b111;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, req_write;
    logic [20:0]  req_address;
    logic [255:0] wr_line, rd_line;
    logic         rd_valid, busy;
    logic         I_sdrc_cmd_en, I_sdrc_precharge_ctrl, I_sdram_power_down, I_sdram_selfrefresh;
    logic [2:0]   I_sdrc_cmd;
    logic [20:0]  I_sdrc_addr;
    logic [3:0]   I_sdrc_dqm;
    logic [31:0]  I_sdrc_data;
    logic [7:0]   I_sdrc_data_len;
    logic [31:0]  O_sdrc_data = '0;
    logic         O_sdrc_init_done;
    logic         O_sdrc_cmd_ack = 1'b0;

    always #5 clk = ~clk;

    sdram_line_port #(
        .LineWordsBitWidth(3), .ActivateWaitCycles(ACT_WAIT), .ReadDataLatency(RD_LAT),
        .RecoveryCycles(REC), .RefreshIntervalCycles(REF_INT), .RefreshWaitCycles(REF_WAIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
        .req_address(req_address), .wr_line(wr_line), .rd_line(rd_line), .rd_valid(rd_valid),
        .busy(busy), .I_sdrc_cmd_en(I_sdrc_cmd_en), .I_sdrc_cmd(I_sdrc_cmd),
        .I_sdrc_precharge_ctrl(I_sdrc_precharge_ctrl), .I_sdram_power_down(I_sdram_power_down),
        .I_sdram_selfrefresh(I_sdram_selfrefresh), .I_sdrc_addr(I_sdrc_addr), .I_sdrc_dqm(I_sdrc_dqm),
        .I_sdrc_data(I_sdrc_data), .I_sdrc_data_len(I_sdrc_data_len), .O_sdrc_data(O_sdrc_data),
        .O_sdrc_init_done(O_sdrc_init_done), .O_sdrc_cmd_ack(O_sdrc_cmd_ack)
    );

    typedef struct packed { logic [2:0] cmd; logic [20:0] addr; } cmd_t;
    cmd_t         exp_cmds[$];
    logic [31:0]  exp_words[$];
    logic [255:0] exp_lines[$];
    logic [31:0]  mem [int];

    int tests = 0, fails = 0, cyc = 0, cyc0 = 0, rdv_count = 0;
    int ack_at = -1, rd_at = -1, wr_at = -1, rd_base = 0, wr_base = 0;
    logic ack_ref = 1'b0, prev_cmd_en = 1'b0;
    int last_act_ack = -1, last_act_cmd = -1, last_rd_cmd = -1, last_rdv = -1;
    int last_ref_cmd = -1, last_ref_ack = -1;

    // Controller model and output scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        cmd_t got, exp;
        cyc++;
        O_sdrc_cmd_ack = 1'b0;
        O_sdrc_data    = '0;
        if (!rst_n) begin
            ack_at = -1; rd_at = -1; wr_at = -1; prev_cmd_en = 1'b0;
        end else begin
            if (ack_at == cyc) begin
                O_sdrc_cmd_ack = 1'b1;
                if (ack_ref) last_ref_ack = cyc; else last_act_ack = cyc;
            end
            if (rd_at >= 0 && cyc >= rd_at && cyc < rd_at + 8)
                O_sdrc_data = mem.exists(rd_base + cyc - rd_at) ? mem[rd_base + cyc - rd_at] : 32'h0;
            tests++;
            if (I_sdrc_cmd_en) begin
                if (prev_cmd_en) begin
                    fails++; $display("FAIL cmd_en_pulse: cmd_en high on consecutive cycles at cycle %0d", cyc);
                end
                got = {I_sdrc_cmd, I_sdrc_addr};
                if (I_sdrc_cmd == C_REF) begin
                    last_ref_cmd = cyc; ack_at = cyc + ACK_DLY; ack_ref = 1'b1;
                end else begin
                    if (exp_cmds.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL cmd_unexpected: got cmd=%b addr=%h, required none", I_sdrc_cmd, I_sdrc_addr);
                    end else begin
                        exp = exp_cmds.pop_front();
                        tests++;
                        if (got !== exp) begin
                            fails++;
                            $display("FAIL cmd_seq: got cmd=%b addr=%h, required cmd=%b addr=%h",
                                     got.cmd, got.addr, exp.cmd, exp.addr);
                        end
                    end
                    if (I_sdrc_cmd == C_ACT) begin
                        ack_at = cyc + ACK_DLY; ack_ref = 1'b0; last_act_cmd = cyc;
                    end else if (I_sdrc_cmd == C_RD || I_sdrc_cmd == C_WR) begin
                        tests++;
                        if (cyc != last_act_ack + ACT_WAIT + 1) begin
                            fails++;
                            $display("FAIL rw_timing: command at cycle %0d, required %0d", cyc, last_act_ack + ACT_WAIT + 1);
                        end
                        if (I_sdrc_cmd == C_RD) begin
                            rd_at = cyc + RD_LAT; rd_base = int'(I_sdrc_addr); last_rd_cmd = cyc;
                        end else begin
                            wr_at = cyc; wr_base = int'(I_sdrc_addr);
                        end
                    end
                end
            end else if (I_sdrc_cmd !== C_NOP) begin
                fails++; $display("FAIL cmd_nop: cmd=%b while cmd_en=0, required %b", I_sdrc_cmd, C_NOP);
            end
            tests++;
            if (wr_at >= 0 && cyc >= wr_at && cyc < wr_at + 8) begin
                mem[wr_base + cyc - wr_at] = I_sdrc_data;
                if (exp_words.size() == 0) begin
                    fails++; $display("FAIL wr_word_unexpected: got %h, required none", I_sdrc_data);
                end else begin
                    exp.addr = '0;
                    if (I_sdrc_data !== exp_words[0]) begin
                        fails++; $display("FAIL wr_word: got %h, required %h", I_sdrc_data, exp_words[0]);
                    end
                    void'(exp_words.pop_front());
                end
            end else if (I_sdrc_data !== 32'h0) begin
                fails++; $display("FAIL data_idle: I_sdrc_data=%h outside burst, required 0", I_sdrc_data);
            end
            if (rd_valid) begin
                rdv_count++; last_rdv = cyc;
                tests++;
                if (cyc != last_rd_cmd + RD_LAT + 8 + 1) begin
                    fails++; $display("FAIL rd_valid_timing: at cycle %0d, required %0d", cyc, last_rd_cmd + RD_LAT + 9);
                end
                tests++;
                if (exp_lines.size() == 0) begin
                    fails++; $display("FAIL rd_unexpected: rd_valid with no read outstanding");
                end else begin
                    if (rd_line !== exp_lines[0]) begin
                        fails++; $display("FAIL rd_line: got %h, required %h", rd_line, exp_lines[0]);
                    end
                    void'(exp_lines.pop_front());
                end
            end
            prev_cmd_en = I_sdrc_cmd_en;
        end
    end

    task automatic tick();
        @(negedge clk); #2;
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
        return l;
    endfunction

    task automatic issue_req(input logic wr, input logic [20:0] a, input logic [255:0] line);
        int n = 0;
        req_write = wr; req_address = a; wr_line = line; req_valid = 1'b1;
        while (busy === 1'b1 && n < 2000) begin tick(); n++; end
        if (n >= 2000) begin
            tests++; fails++; $display("FAIL req_accept: busy=%b after %0d cycles, required 0", busy, n);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((busy || I_sdrc_cmd_en || exp_cmds.size() != 0 || exp_words.size() != 0 ||
                exp_lines.size() != 0) && n < 3000) begin
            tick(); n++;
        end
        tests++;
        if (n >= 3000) begin
            fails++;
            $display("FAIL drain: cmds=%0d words=%0d lines=%0d busy=%b left, required all empty",
                     exp_cmds.size(), exp_words.size(), exp_lines.size(), busy);
        end
    endtask

    task automatic push_req(input logic wr, input logic [20:0] a, input logic [255:0] line);
        logic [20:0] al;
        al = a & 21'h1F_FFF8;
        exp_cmds.push_back({C_ACT, a[20:8], 8'h00});
        exp_cmds.push_back({wr ? C_WR : C_RD, al});
        if (wr) for (int i = 0; i < 8; i++) exp_words.push_back(line[32*i +: 32]);
        else exp_lines.push_back(line);
    endtask

    task automatic test_reset();
        int bad_busy = 0, bad_cmd = 0;
        rst_n = 1'b0; O_sdrc_init_done = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_address = '0; wr_line = '0;
        repeat (3) tick();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b, required 1", busy); end
        tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %b, required 0", rd_valid); end
        tests++; if (rd_line !== '0) begin fails++; $display("FAIL reset_rd_line: got %h, required 0", rd_line); end
        tests++;
        if ({I_sdrc_cmd_en, I_sdrc_cmd, I_sdrc_addr, I_sdrc_data} !== {1'b0, C_NOP, 21'h0, 32'h0}) begin
            fails++; $display("FAIL reset_cmd: got en=%b cmd=%b addr=%h data=%h, required 0/111/0/0",
                              I_sdrc_cmd_en, I_sdrc_cmd, I_sdrc_addr, I_sdrc_data);
        end
        tests++;
        if ({I_sdrc_precharge_ctrl, I_sdram_power_down, I_sdram_selfrefresh, I_sdrc_dqm, I_sdrc_data_len} !==
            {1'b1, 1'b0, 1'b0, 4'h0, 8'd7}) begin
            fails++; $display("FAIL const_outs: got pc=%b pd=%b sr=%b dqm=%h len=%0d, required 1/0/0/0/7",
                              I_sdrc_precharge_ctrl, I_sdram_power_down, I_sdram_selfrefresh, I_sdrc_dqm, I_sdrc_data_len);
        end
        rst_n = 1'b1; cyc0 = cyc;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (busy !== 1'b1) bad_busy++;
            if (I_sdrc_cmd_en !== 1'b0) bad_cmd++;
        end
        tests++; if (bad_busy != 0) begin fails++; $display("FAIL init_busy: busy low %0d cycles, required 0", bad_busy); end
        tests++; if (bad_cmd != 0) begin fails++; $display("FAIL init_cmd: %0d cmd_en pulses, required 0", bad_cmd); end
        O_sdrc_init_done = 1'b1;
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL init_done_busy: got %b, required 0", busy); end
    endtask

    task automatic test_write_read();
        logic [255:0] line;
        int rdv0;
        line = make_line(32'h1111_0000);
        push_req(1'b1, 21'h1A_3F08, line);
        issue_req(1'b1, 21'h1A_3F08, line);
        rdv0 = rdv_count;
        push_req(1'b0, 21'h1A_3F08, line);
        issue_req(1'b0, 21'h1A_3F08, '0);
        wait_drain();
        tests++;
        if (rdv_count - rdv0 != 1) begin fails++; $display("FAIL rd_valid_count: got %0d pulses, required 1", rdv_count - rdv0); end
    endtask

    task automatic test_unaligned();
        logic [255:0] line;
        line = make_line(32'hA5A5_0000);
        push_req(1'b1, 21'h00_0007, line);
        issue_req(1'b1, 21'h00_0007, line);
        push_req(1'b0, 21'h00_0007, line);
        issue_req(1'b0, 21'h00_0007, '0);
        wait_drain();
    endtask

    task automatic test_refresh();
        logic [255:0] rline, wline;
        int due;
        wait_drain();
        due = cyc0 + REF_INT;
        while (due < cyc + 40) due += REF_INT;
        while (cyc < due - 15) tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL refresh_setup: busy=%b, required 0", busy); end
        rline = make_line(32'hC0DE_0000);
        for (int i = 0; i < 8; i++) mem[int'(21'h05_1230) + i] = rline[32*i +: 32];
        push_req(1'b0, 21'h05_1230, rline);
        issue_req(1'b0, 21'h05_1230, '0);
        wline = make_line(32'h7777_0000);
        push_req(1'b1, 21'h05_1240, wline);
        issue_req(1'b1, 21'h05_1240, wline);
        wait_drain();
        tests++;
        if (!(last_ref_cmd > last_rdv && last_ref_cmd < last_act_cmd)) begin
            fails++; $display("FAIL refresh_order: refresh %0d, rd_valid %0d, active %0d, required rd_valid<refresh<active",
                              last_ref_cmd, last_rdv, last_act_cmd);
        end
        tests++;
        if (last_act_cmd != last_ref_ack + REF_WAIT + 2) begin
            fails++; $display("FAIL refresh_wait: active at %0d, required %0d", last_act_cmd, last_ref_ack + REF_WAIT + 2);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] la, lb;
        int rdv0;
        la = make_line(32'hB0B0_0000);
        lb = make_line(32'hB3B3_0000);
        for (int i = 0; i < 8; i++) begin
            mem[int'(21'h00_4A10) + i] = la[32*i +: 32];
            mem[int'(21'h1C_7720) + i] = lb[32*i +: 32];
        end
        rdv0 = rdv_count;
        push_req(1'b0, 21'h00_4A10, la);
        issue_req(1'b0, 21'h00_4A10, '0);
        push_req(1'b0, 21'h1C_7720, lb);
        issue_req(1'b0, 21'h1C_7720, '0);
        wait_drain();
        tests++;
        if (rdv_count - rdv0 != 2) begin fails++; $display("FAIL b2b_count: got %0d pulses, required 2", rdv_count - rdv0); end
    endtask

    task automatic test_reset_mid_write();
        logic [255:0] line;
        int start, n, bad_busy;
        line = make_line(32'hDEAD_0000);
        start = cyc; n = 0; bad_busy = 0;
        push_req(1'b1, 21'h0A_0100, line);
        issue_req(1'b1, 21'h0A_0100, line);
        while (!(wr_at > start && cyc == wr_at + 3) && n < 200) begin tick(); n++; end
        tests++; if (n >= 200) begin fails++; $display("FAIL mid_write_wait: word 3 not reached in %0d cycles", n); end
        rst_n = 1'b0; O_sdrc_init_done = 1'b0;
        #1;
        tests++;
        if ({busy, rd_valid, I_sdrc_cmd_en, I_sdrc_cmd, I_sdrc_addr, I_sdrc_data} !==
            {1'b1, 1'b0, 1'b0, C_NOP, 21'h0, 32'h0}) begin
            fails++; $display("FAIL async_reset: busy=%b rdv=%b en=%b cmd=%b addr=%h data=%h, required 1/0/0/111/0/0",
                              busy, rd_valid, I_sdrc_cmd_en, I_sdrc_cmd, I_sdrc_addr, I_sdrc_data);
        end
        tests++; if (rd_line !== '0) begin fails++; $display("FAIL async_reset_rd_line: got %h, required 0", rd_line); end
        exp_cmds.delete(); exp_words.delete(); exp_lines.delete();
        repeat (3) tick();
        rst_n = 1'b1; cyc0 = cyc;
        for (int i = 0; i < 5; i++) begin tick(); if (busy !== 1'b1) bad_busy++; end
        tests++; if (bad_busy != 0) begin fails++; $display("FAIL reinit_busy: busy low %0d cycles, required 0", bad_busy); end
        O_sdrc_init_done = 1'b1;
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reinit_done: busy=%b, required 0", busy); end
        push_req(1'b0, 21'h1C_7720, make_line(32'hB3B3_0000));
        issue_req(1'b0, 21'h1C_7720, '0);
        wait_drain();
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_unaligned();
        test_refresh();
        test_back_to_back();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sdram_line_port.md
# sdram_line_port

Sequencer between the cache in `ramio` and the Gowin `SDRAM_Controller_HS_Top`. It turns whole cache-line read and write requests into the controller's command sequence: activate, then read or write burst with auto-precharge, then recovery. It also issues periodic auto-refresh and holds off all traffic until `O_sdrc_init_done`. Upstream sees a single-request valid/busy handshake with a flat line buffer. Downstream it drives the `I_sdrc_*` port set directly.

## Interface
Parameters:
- `LineWordsBitWidth`, 3 — line = 2^3 = 8 words of 32 bits.
- `ActivateWaitCycles`, 2 — cycles after the activate ack before the read/write command.
- `ReadDataLatency`, 6 — cycles from the read `cmd_en` cycle to the first valid `O_sdrc_data` word.
- `RecoveryCycles`, 4 — idle cycles after the last burst word (tWR + tRP, auto-precharge).
- `RefreshIntervalCycles`, 300 — cycles between auto-refresh requests.
- `RefreshWaitCycles`, 8 — tRFC cycles after the refresh ack.

Ports:
- `clk` in 1 — single clock, shared with the controller.
- `rst_n` in 1 — asynchronous, active-low reset.
- `req_valid` in 1 — request strobe; sampled only while `busy`=0.
- `req_write` in 1 — 1 = write line, 0 = read line.
- `req_address` in 21 — RAM word address {bank[20:19], row[18:8], col[7:0]}; low `LineWordsBitWidth` bits are ignored (forced 0).
- `wr_line` in 256 — write data; word i = bits [32i+31:32i]; captured with the request.
- `rd_line` out 256 — read data; valid while `rd_valid`=1, held until the next read completes.
- `rd_valid` out 1 — one-cycle pulse when `rd_line` is complete.
- `busy` out 1 — 1 when a request cannot be accepted.
- `I_sdrc_cmd_en` out 1, `I_sdrc_cmd` out 3, `I_sdrc_precharge_ctrl` out 1, `I_sdram_power_down` out 1, `I_sdram_selfrefresh` out 1, `I_sdrc_addr` out 21, `I_sdrc_dqm` out 4, `I_sdrc_data` out 32, `I_sdrc_data_len` out 8 — controller interface.
- `O_sdrc_data` in 32, `O_sdrc_init_done` in 1, `O_sdrc_cmd_ack` in 1 — from the controller.

## Operation
- Command codes: ACTIVE 3'b011, READ 3'b101, WRITE 3'b100, REFRESH 3'b001, NOP 3'b111.
- Constant outputs:
  - `I_sdrc_precharge_ctrl` = 1 (auto-precharge).
  - `I_sdram_power_down` = 0 and `I_sdram_selfrefresh` = 0.
  - `I_sdrc_dqm` = 0.
  - `I_sdrc_data_len` = 2^LineWordsBitWidth − 1.
- States and transitions:
  - INIT: wait for `O_sdrc_init_done`, then go to IDLE.
  - IDLE:
    - If refresh is pending, issue REFRESH and go to REF_ACK.
    - Else, on `req_valid`, latch `req_write`, the aligned address and `wr_line`; issue ACTIVE with `I_sdrc_addr` = {bank, row, 8'h00}; go to ACT_ACK.
  - ACT_ACK: wait for `O_sdrc_cmd_ack`, then go to ACT_WAIT.
  - ACT_WAIT: count `ActivateWaitCycles`; then issue READ or WRITE with `I_sdrc_addr` = {bank, row, col}.
  - WRITE → WR_DATA: drive words 0..N−1 on `I_sdrc_data`, one per cycle. Word 0 is driven in the WRITE `cmd_en` cycle. Then go to RECOVER.
  - READ → RD_WAIT: count `ReadDataLatency`, then go to RD_DATA.
  - RD_DATA: capture N consecutive words into `rd_line[32i+:32]`. Pulse `rd_valid` the cycle after the last capture. Then go to RECOVER.
  - RECOVER: count `RecoveryCycles`, then go to IDLE.
  - REF_ACK: wait for the ack, count `RefreshWaitCycles`, then go to IDLE.
- Refresh timer:
  - Free-running down-counter from `RefreshIntervalCycles`−1.
  - At 0 it sets `refresh_pending` and reloads.
  - `refresh_pending` is cleared when REFRESH is issued.
  - A refresh that falls due mid-request is served at the next IDLE, ahead of any waiting `req_valid`.
- `I_sdrc_cmd_en` is a one-cycle pulse per command. `I_sdrc_cmd` = NOP whenever `cmd_en` = 0.
- `busy` = 1 in every state except IDLE. It is also 1 in IDLE while refresh is pending.
- `I_sdrc_data` = 0 outside WR_DATA.

## Timing
- Reset values:
  - State INIT; `busy` 1; `rd_valid` 0; `rd_line` 0.
  - `I_sdrc_cmd_en` 0; `I_sdrc_cmd` NOP; `I_sdrc_addr` 0; `I_sdrc_data` 0.
  - Refresh counter reloaded; `refresh_pending` 0.
- Accept: `req_valid` && !`busy` in cycle t. ACTIVE `cmd_en` is registered, so it appears at t+1.
- Read latency, ack in k cycles: ACTIVE at t+1; READ at t+1+k+`ActivateWaitCycles`+1; `rd_valid` = READ cycle + `ReadDataLatency` + 8 + 1.
- `busy` falls `RecoveryCycles` after the last data cycle.
- `req_valid` while `busy`=1 is ignored; upstream must hold it.
- Reset mid-operation: immediate return to reset values. The command in flight is abandoned, and the block re-waits for `O_sdrc_init_done`.
- If `O_sdrc_init_done` drops in any state, go to INIT at the next clock.

## Test plan
- Reset, then hold `init_done` = 0 for 50 cycles: `busy` = 1 throughout and no `cmd_en` pulses; `init_done` = 1 → `busy` = 0 one cycle later.
- Write line addr 21'h1A_3F08, words 32'h1111_0000 + i, then read back the same address: ACTIVE addr 21'h1A_3F00, WRITE addr 21'h1A_3F08, words in order; `rd_line` equals the written words and `rd_valid` pulses exactly once.
- `req_address` 21'h00_0007 (unaligned): WRITE/READ column = 8'h00.
- Let the refresh counter expire while a read is in RD_DATA: read completes intact; next IDLE issues REFRESH before a queued `req_valid`; the write is served after the RefreshWaitCycles window.
- Back-to-back reads in banks 0 and 3 with the SDRAM model: each `rd_valid` matches preloaded data; no overlap of `cmd_en` pulses.
- Assert `rst_n` = 0 during WR_DATA word 3: all outputs return to reset values the same cycle (async); after reset the block restarts from INIT.
